dmem_sram_ctrl: RTL and testbench
=================================

Name: dmem_sram_ctrl

Overview:
- Multi-cycle access controller between the MEM stage data-memory request (read enable, write enable, ALU address, Rm store data) and an external 16-bit asynchronous SRAM.
- Each 32-bit word is split into two 16-bit beats with a programmable wait-state count per beat.
- Asserts freeze to stall the pipeline until the access completes.
- Returns the assembled 32-bit read word to the MEM/WB path.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 3: clock cycles per 16-bit beat; legal range 1..15.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset; sampled on clk rising edge, rst=0 resets.
- MEM_r_en  in  1  load request from MEM stage.
- MEM_w_en  in  1  store request from MEM stage.
- address  in  32  byte address (ALU result).
- data_in  in  32  store data (Val_Rm).
- freeze  out  1  pipeline stall.
- data_out  out  32  read word; valid in DONE and held until next read completes.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_oe  out  1  1 = controller drives DQ.
- sram_dq_in  in  16  read data from SRAM.
- sram_we_n  out  1  active-low write strobe.

Behaviour:
- Reset values (rst=0 at edge):
  - state=IDLE, counter=0, data_out=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - freeze=0 (IDLE with requests ignored during reset).
- Reset mid-access aborts immediately:
  - sram_we_n=1 on that edge.
  - Partial read data discarded, data_out=0.
- Request qualification:
  - req = MEM_r_en | MEM_w_en.
  - Both asserted is treated as write; the read is ignored.
- Address map:
  - word = (address - BASE_ADDR) >> 2, modulo 2^32; no range check.
  - sram_addr = {word[SRAM_AW-2:0], beat}, beat 0 = low half, beat 1 = high half.
  - address[1:0] ignored.
- FSM states IDLE, LO, HI, DONE; cnt is 4-bit.
  - IDLE:
    - freeze = req (combinational).
    - On req: latch is_write, word address, data_in; cnt<=0; go to LO.
  - LO:
    - freeze=1; beat=0.
    - On write: sram_dq_oe=1 and sram_dq_out=wdata[15:0].
    - cnt increments each cycle.
    - When cnt==WAIT_CYCLES-1: on read, capture sram_dq_in into data_out[15:0]; cnt<=0; go to HI.
  - HI:
    - Same as LO with beat=1 and wdata[31:16].
    - Read capture goes to data_out[31:16].
    - Exit to DONE.
  - DONE:
    - freeze=0; SRAM idle (dq_oe=0, we_n=1).
    - Go to IDLE unconditionally.
    - The request still present this cycle belongs to the instruction now advancing, so it is not re-accepted.
- Write strobe timing:
  - sram_we_n=0 during a write beat on cycles cnt < WAIT_CYCLES-1; high on the final cycle of each beat so it rises before the address changes.
  - For WAIT_CYCLES=1, we_n=0 for the whole single cycle.
- Output timing:
  - sram_addr, sram_dq_out, sram_dq_oe and sram_we_n are decoded only from registered state, cnt and latched request, never from live inputs.
  - Outside a write beat, sram_dq_oe=0 and sram_we_n=1.
- Latency:
  - Request seen in IDLE at cycle 0; LO occupies cycles 1..W, HI occupies W+1..2W, DONE is cycle 2W+1.
  - freeze is high for exactly 2W+1 consecutive cycles.
  - data_out is valid from cycle 2W+1.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, giving one non-frozen cycle between accesses.
- data_out is unchanged by writes and by idle cycles.

Test Plan:
- Reset: rst=0 for 2 cycles with MEM_r_en=1 -> freeze=0, sram_we_n=1, sram_dq_oe=0, data_out=0; after rst=1 the read is accepted on the next edge.
- Read, W=3: address=1028, SRAM model returns 0xBEEF at half-word 2 and 0xDEAD at half-word 3.
  - sram_addr goes 2 then 3.
  - freeze is high for 7 cycles; data_out=0xDEADBEEF in DONE.
- Write, W=3: address=1024, data_in=0x12345678.
  - Beat 0: sram_addr=0, dq_out=0x5678, we_n low 2 cycles then high 1 cycle, dq_oe=1 for 3 cycles.
  - Beat 1: sram_addr=1 with 0x1234, same strobe pattern.
  - freeze high 7 cycles.
- Both enables set, W=1: MEM_r_en=MEM_w_en=1 -> write performed, we_n low 1 cycle per beat, data_out unchanged, freeze high 3 cycles.
- Back-to-back reads held continuously with different addresses -> pattern is 7 frozen cycles, 1 DONE cycle, 7 frozen cycles; second data_out correct and no duplicate access.
- Reset mid-write: assert rst=0 while in HI -> next cycle state IDLE, we_n=1, dq_oe=0, freeze follows req only after rst=1.

Source files
------------

// File: rtl/dmem_sram_ctrl.sv
// MEM-stage data-memory controller that splits each 32-bit access into two
// 16-bit beats on an asynchronous SRAM and stalls the pipeline until done.
module dmem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 3,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_r_en,
    input  logic               MEM_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        data_in,
    output logic               freeze,
    output logic [31:0]        data_out,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [3:0]         r_cnt;
    logic               r_isWrite;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_dataOut;

    logic               w_req;
    logic               w_lastCycle;
    logic               w_writeBeat;
    logic [31:0]        w_diff;
    logic               w_unused;

    assign w_req       = MEM_r_en | MEM_w_en;
    assign w_diff      = address - BASE_ADDR;
    assign w_lastCycle = (r_cnt == LAST_CNT);
    assign w_writeBeat = r_isWrite && ((r_state == LO) || (r_state == HI));
    assign w_unused    = &{1'b0, w_diff[31:SRAM_AW+1], w_diff[1:0]};
    assign data_out    = r_dataOut;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_req) w_nextState = LO;
            LO:      if (w_lastCycle) w_nextState = HI;
            HI:      if (w_lastCycle) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Word index is (address - BASE_ADDR) >> 2, i.e. bits [SRAM_AW:2] of the difference.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= 4'd0;
            r_isWrite <= 1'b0;
            r_word    <= '0;
            r_wdata   <= 32'd0;
            r_dataOut <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_isWrite <= MEM_w_en;
                        r_word    <= w_diff[SRAM_AW:2];
                        r_wdata   <= data_in;
                        r_cnt     <= 4'd0;
                    end
                end
                LO, HI: begin
                    if (w_lastCycle) begin
                        r_cnt <= 4'd0;
                        if (!r_isWrite) begin
                            if (r_state == LO) r_dataOut[15:0]  <= sram_dq_in;
                            else               r_dataOut[31:16] <= sram_dq_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe releases on the last cycle of a beat so WE# rises before the address moves.
    always_comb begin
        freeze      = 1'b0;
        sram_addr   = {r_word, 1'b0};
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (r_state)
            IDLE: freeze = rst & w_req;
            LO, HI: begin
                freeze = 1'b1;
                if (r_state == HI) sram_addr = {r_word, 1'b1};
                if (w_writeBeat) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
                    sram_we_n   = !(!w_lastCycle || (WAIT_CYCLES == 1));
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl: one instance with 3 wait states, one with 1,
// both reading from a fixed half-word lookup acting as the SRAM.
module tb_dmem_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        rEn, wEn;
    logic [31:0] addr, wdata;
    logic        freeze3, oe3, weN3;
    logic [31:0] dataOut3;
    logic [17:0] sramAddr3;
    logic [15:0] dqOut3, dqIn3;

    logic        rEn1, wEn1;
    logic [31:0] addr1, wdata1;
    logic        freeze1, oe1, weN1;
    logic [31:0] dataOut1;
    logic [17:0] sramAddr1;
    logic [15:0] dqOut1, dqIn1;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] sramModel(input logic [17:0] a);
        case (a)
            18'd2:   return 16'hBEEF;
            18'd3:   return 16'hDEAD;
            18'd4:   return 16'h1111;
            18'd5:   return 16'h2222;
            18'd6:   return 16'h3333;
            18'd7:   return 16'h4444;
            18'd10:  return 16'hCAFE;
            18'd11:  return 16'hF00D;
            default: return 16'h0000;
        endcase
    endfunction

    assign dqIn3 = sramModel(sramAddr3);
    assign dqIn1 = sramModel(sramAddr1);

    dmem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3), .SRAM_AW(18)) dut3 (
        .clk(clk), .rst(rst), .MEM_r_en(rEn), .MEM_w_en(wEn), .address(addr),
        .data_in(wdata), .freeze(freeze3), .data_out(dataOut3), .sram_addr(sramAddr3),
        .sram_dq_out(dqOut3), .sram_dq_oe(oe3), .sram_dq_in(dqIn3), .sram_we_n(weN3)
    );

    dmem_sram_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
        .clk(clk), .rst(rst), .MEM_r_en(rEn1), .MEM_w_en(wEn1), .address(addr1),
        .data_in(wdata1), .freeze(freeze1), .data_out(dataOut1), .sram_addr(sramAddr1),
        .sram_dq_out(dqOut1), .sram_dq_oe(oe1), .sram_dq_in(dqIn1), .sram_we_n(weN1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                                 input logic [31:0] d);
        rEn = r; wEn = w; addr = a; wdata = d;
        #1;
    endtask

    task automatic applyStimulus1(input logic r, input logic w, input logic [31:0] a,
                                  input logic [31:0] d);
        rEn1 = r; wEn1 = w; addr1 = a; wdata1 = d;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus1(0, 0, 32'd0, 32'd0);
        applyStimulus(1, 0, 32'd1028, 32'd0);

        // Reset held with a pending read: nothing accepted, outputs at reset values
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            checkOutput("rst_freeze",   32'(freeze3),   32'd0);
            checkOutput("rst_we_n",     32'(weN3),      32'd1);
            checkOutput("rst_dq_oe",    32'(oe3),       32'd0);
            checkOutput("rst_data_out", dataOut3,       32'd0);
            checkOutput("rst_sram_addr", 32'(sramAddr3), 32'd0);
        end

        // Read at 1028 (half-words 2,3) with 3 wait states
        rst = 1'b1;
        #1;
        checkOutput("rd_c0_freeze", 32'(freeze3), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            nextCycle();
            checkOutput("rd_freeze", 32'(freeze3), (c < 7) ? 32'd1 : 32'd0);
            if (c < 7) begin
                checkOutput("rd_sram_addr", 32'(sramAddr3), (c <= 3) ? 32'd2 : 32'd3);
                checkOutput("rd_we_n", 32'(weN3), 32'd1);
                checkOutput("rd_dq_oe", 32'(oe3), 32'd0);
            end else begin
                checkOutput("rd_data_out", dataOut3, 32'hDEADBEEF);
                applyStimulus(0, 0, 32'd0, 32'd0);
            end
        end
        nextCycle();
        checkOutput("rd_idle_freeze", 32'(freeze3), 32'd0);

        // Write 0x12345678 at 1024: two beats, WE# low 2 cycles then high 1
        applyStimulus(0, 1, 32'd1024, 32'h12345678);
        checkOutput("wr_c0_freeze", 32'(freeze3), 32'd1);
        for (int c = 1; c <= 7; c++) begin
            nextCycle();
            checkOutput("wr_freeze", 32'(freeze3), (c < 7) ? 32'd1 : 32'd0);
            if (c < 7) begin
                checkOutput("wr_sram_addr", 32'(sramAddr3), (c <= 3) ? 32'd0 : 32'd1);
                checkOutput("wr_dq_out", 32'(dqOut3), (c <= 3) ? 32'h5678 : 32'h1234);
                checkOutput("wr_dq_oe", 32'(oe3), 32'd1);
                checkOutput("wr_we_n", 32'(weN3), (c == 3 || c == 6) ? 32'd1 : 32'd0);
            end else begin
                checkOutput("wr_done_dq_oe", 32'(oe3), 32'd0);
                checkOutput("wr_done_we_n", 32'(weN3), 32'd1);
                checkOutput("wr_data_out_held", dataOut3, 32'hDEADBEEF);
                applyStimulus(0, 0, 32'd0, 32'd0);
            end
        end
        nextCycle();

        // Back-to-back reads with the request held through DONE
        applyStimulus(1, 0, 32'd1032, 32'd0);
        checkOutput("b2b_c0_freeze", 32'(freeze3), 32'd1);
        for (int c = 1; c <= 16; c++) begin
            nextCycle();
            checkOutput("b2b_freeze", 32'(freeze3),
                        ((c < 7) || (c >= 8 && c <= 14)) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 3)   checkOutput("b2b_addr_a_lo", 32'(sramAddr3), 32'd4);
            if (c >= 4 && c <= 6)   checkOutput("b2b_addr_a_hi", 32'(sramAddr3), 32'd5);
            if (c >= 9 && c <= 11)  checkOutput("b2b_addr_b_lo", 32'(sramAddr3), 32'd6);
            if (c >= 12 && c <= 14) checkOutput("b2b_addr_b_hi", 32'(sramAddr3), 32'd7);
            if (c == 7 || c == 8)   checkOutput("b2b_data_a", dataOut3, 32'h22221111);
            if (c == 15)            checkOutput("b2b_data_b", dataOut3, 32'h44443333);
            if (c == 7)  applyStimulus(1, 0, 32'd1036, 32'd0);
            if (c == 15) applyStimulus(0, 0, 32'd0, 32'd0);
        end

        // Reset asserted during the high write beat
        applyStimulus(0, 1, 32'd1040, 32'hAAAA5555);
        for (int c = 1; c <= 4; c++) nextCycle();
        checkOutput("rstmid_hi_we_n", 32'(weN3), 32'd0);
        checkOutput("rstmid_hi_addr", 32'(sramAddr3), 32'd9);
        checkOutput("rstmid_hi_dq", 32'(dqOut3), 32'hAAAA);
        rst = 1'b0;
        nextCycle();
        checkOutput("rstmid_we_n", 32'(weN3), 32'd1);
        checkOutput("rstmid_dq_oe", 32'(oe3), 32'd0);
        checkOutput("rstmid_freeze", 32'(freeze3), 32'd0);
        checkOutput("rstmid_data_out", dataOut3, 32'd0);
        checkOutput("rstmid_addr", 32'(sramAddr3), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_freeze_req", 32'(freeze3), 32'd1);
        applyStimulus(0, 0, 32'd0, 32'd0);
        checkOutput("rstmid_freeze_noreq", 32'(freeze3), 32'd0);
        nextCycle();
        checkOutput("rstmid_idle_freeze", 32'(freeze3), 32'd0);
        checkOutput("rstmid_idle_we_n", 32'(weN3), 32'd1);

        // One wait state: read at 1044 (half-words 10,11)
        applyStimulus1(1, 0, 32'd1044, 32'd0);
        checkOutput("w1_rd_c0_freeze", 32'(freeze1), 32'd1);
        nextCycle();
        checkOutput("w1_rd_lo_freeze", 32'(freeze1), 32'd1);
        checkOutput("w1_rd_lo_addr", 32'(sramAddr1), 32'd10);
        nextCycle();
        checkOutput("w1_rd_hi_addr", 32'(sramAddr1), 32'd11);
        nextCycle();
        checkOutput("w1_rd_done_freeze", 32'(freeze1), 32'd0);
        checkOutput("w1_rd_data_out", dataOut1, 32'hF00DCAFE);
        applyStimulus1(0, 0, 32'd0, 32'd0);
        nextCycle();
        checkOutput("w1_idle_freeze", 32'(freeze1), 32'd0);

        // Both enables set: performed as a write, data_out unchanged
        applyStimulus1(1, 1, 32'd1024, 32'h9ABCDEF0);
        checkOutput("w1_both_c0_freeze", 32'(freeze1), 32'd1);
        nextCycle();
        checkOutput("w1_both_lo_freeze", 32'(freeze1), 32'd1);
        checkOutput("w1_both_lo_we_n", 32'(weN1), 32'd0);
        checkOutput("w1_both_lo_oe", 32'(oe1), 32'd1);
        checkOutput("w1_both_lo_addr", 32'(sramAddr1), 32'd0);
        checkOutput("w1_both_lo_dq", 32'(dqOut1), 32'hDEF0);
        nextCycle();
        checkOutput("w1_both_hi_freeze", 32'(freeze1), 32'd1);
        checkOutput("w1_both_hi_we_n", 32'(weN1), 32'd0);
        checkOutput("w1_both_hi_addr", 32'(sramAddr1), 32'd1);
        checkOutput("w1_both_hi_dq", 32'(dqOut1), 32'h9ABC);
        nextCycle();
        checkOutput("w1_both_done_freeze", 32'(freeze1), 32'd0);
        checkOutput("w1_both_done_we_n", 32'(weN1), 32'd1);
        checkOutput("w1_both_done_oe", 32'(oe1), 32'd0);
        checkOutput("w1_both_data_held", dataOut1, 32'hF00DCAFE);
        applyStimulus1(0, 0, 32'd0, 32'd0);
        nextCycle();
        checkOutput("w1_both_idle_freeze", 32'(freeze1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
